// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with an in-order prefetch queue.
// Requests go to a variable-latency instruction memory (valid/ready request,
// valid-only in-order response). A small pending list holds the PC and a
// kill flag for every accepted-but-unanswered request. Returned words land
// in a first-word-fall-through queue that feeds decode.
// Optional feature: define FETCH_PERF_COUNTERS_EN to add the
// fetchStallCycles / fetchFlushedWords saturating counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h00000000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isStalled,
    input  logic        shouldGoToTarget,
    input  logic [31:0] jumpTarget,
    output logic        memReqValid,
    output logic [31:0] memReqAddress,
    input  logic        memReqReady,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    output logic        instructionValid,
    output logic [31:0] instruction,
    output logic [31:0] instructionPc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetchStallCycles,
    output logic [31:0] fetchFlushedWords
`endif
);

    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    // fetch address and pending-request bookkeeping
    logic [31:0]    r_fetchPc;
    logic [31:0]    r_pendPc   [MAX_OUTSTANDING];
    logic           r_pendKill [MAX_OUTSTANDING];
    logic [PAW-1:0] r_pHead, r_pTail;
    logic [OCW-1:0] r_outstanding;

    // prefetch queue
    logic [31:0]    r_qData [QUEUE_DEPTH];
    logic [31:0]    r_qPc   [QUEUE_DEPTH];
    logic [QAW-1:0] r_qHead, r_qTail;
    logic [QCW-1:0] r_qCount;

    logic           w_accept;
    logic           w_respPop;
    logic           w_qPush;
    logic           w_qPop;
    logic           w_qEmpty;
    logic           w_creditOk;
    logic [PAW-1:0] w_pHeadNext, w_pTailNext;

    // Credits count both queued words and words still in flight, so every
    // response that comes back is guaranteed a queue slot.
    assign w_creditOk = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                        ((int'(r_qCount) + int'(r_outstanding)) < QUEUE_DEPTH);

    assign memReqValid   = !reset && !shouldGoToTarget && w_creditOk;
    assign memReqAddress = r_fetchPc;
    assign w_accept      = memReqValid && memReqReady;

    // A response with nothing pending (e.g. a leftover from before reset) is ignored.
    assign w_respPop = memRespValid && (r_outstanding != '0);
    assign w_qPush   = w_respPop && !r_pendKill[r_pHead] && !shouldGoToTarget;

    assign w_qEmpty         = (r_qCount == '0);
    assign instructionValid = !reset && !w_qEmpty && !shouldGoToTarget;
    assign instruction      = w_qEmpty ? 32'h0 : r_qData[r_qHead];
    assign instructionPc    = w_qEmpty ? 32'h0 : r_qPc[r_qHead];
    assign w_qPop           = instructionValid && !isStalled;

    // pending list may be a non-power-of-two depth, so wrap explicitly
    assign w_pHeadNext = (r_pHead == PAW'(MAX_OUTSTANDING - 1)) ? '0 : r_pHead + PAW'(1);
    assign w_pTailNext = (r_pTail == PAW'(MAX_OUTSTANDING - 1)) ? '0 : r_pTail + PAW'(1);

    // fetch PC, pending list and outstanding count; redirect kills in-flight words
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetchPc     <= RESET_PC;
            r_pHead       <= '0;
            r_pTail       <= '0;
            r_outstanding <= '0;
        end else begin
            if (shouldGoToTarget)
                r_fetchPc <= jumpTarget;
            else if (w_accept)
                r_fetchPc <= r_fetchPc + 32'd4;
            if (w_accept) begin
                r_pendPc[r_pTail] <= r_fetchPc;
                r_pTail           <= w_pTailNext;
            end
            if (w_respPop)
                r_pHead <= w_pHeadNext;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (shouldGoToTarget)
                    r_pendKill[i] <= 1'b1;
                else if (w_accept && (r_pTail == PAW'(i)))
                    r_pendKill[i] <= 1'b0;
            end
            r_outstanding <= r_outstanding + OCW'(w_accept) - OCW'(w_respPop);
        end
    end

    // prefetch queue: push returned live words, pop on decode accept, clear on redirect
    always_ff @(posedge clk) begin
        if (reset || shouldGoToTarget) begin
            r_qHead  <= '0;
            r_qTail  <= '0;
            r_qCount <= '0;
        end else begin
            if (w_qPush) begin
                r_qData[r_qTail] <= memRespData;
                r_qPc[r_qTail]   <= r_pendPc[r_pHead];
                r_qTail          <= r_qTail + QAW'(1);
            end
            if (w_qPop)
                r_qHead <= r_qHead + QAW'(1);
            r_qCount <= r_qCount + QCW'(w_qPush) - QCW'(w_qPop);
        end
    end

    // the credit rule makes a push into a full queue without a pop impossible
    assert property (@(posedge clk) disable iff (reset)
        !(w_qPush && !w_qPop && (r_qCount == QCW'(QUEUE_DEPTH))));

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] r_stallCnt, r_flushCnt;
    assign fetchStallCycles  = r_stallCnt;
    assign fetchFlushedWords = r_flushCnt;

    // saturating counters for idle request cycles and discarded responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!memReqValid && !shouldGoToTarget && (r_stallCnt != 32'hFFFFFFFF))
                r_stallCnt <= r_stallCnt + 32'd1;
            if (w_respPop && !w_qPush && (r_flushCnt != 32'hFFFFFFFF))
                r_flushCnt <= r_flushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit. A behavioural memory answers
// requests in order after a random latency; the expected instruction stream
// is simply "consecutive PCs from the last reset/redirect", held in a queue
// and popped by an independent monitor whenever decode consumes a word.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'hFFFFFFF0;
    localparam int          QD  = 4;
    localparam int          MO  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        isStalled = 1'b0;
    logic        shouldGoToTarget = 1'b0;
    logic [31:0] jumpTarget = 32'h0;
    logic        memReqValid;
    logic [31:0] memReqAddress;
    logic        memReqReady = 1'b0;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = 32'h0;
    logic        instructionValid;
    logic [31:0] instruction;
    logic [31:0] instructionPc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetchStallCycles;
    logic [31:0] fetchFlushedWords;
`endif

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .isStalled(isStalled),
        .shouldGoToTarget(shouldGoToTarget), .jumpTarget(jumpTarget),
        .memReqValid(memReqValid), .memReqAddress(memReqAddress),
        .memReqReady(memReqReady), .memRespValid(memRespValid),
        .memRespData(memRespData), .instructionValid(instructionValid),
        .instruction(instruction), .instructionPc(instructionPc)
`ifdef FETCH_PERF_COUNTERS_EN
        , .fetchStallCycles(fetchStallCycles), .fetchFlushedWords(fetchFlushedWords)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = RPC;
    logic [31:0] exp_req  = RPC;
    int          vectors = 0, errors = 0, cyc = 0, epoch = 0, live = 0, consumed = 0;
    bit          m_rst = 1'b0, m_rst2 = 1'b0, m_reqv = 1'b0, m_iv = 1'b0, m_cons = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // monitor: compares DUT outputs against the model, pops the scoreboard on consumption
    always @(negedge clk) begin
        #2;
        if (m_rst2) begin
            chk("rst_reqValid", 32'(memReqValid), 32'(1'b0));
            chk("rst_instrValid", 32'(instructionValid), 32'(1'b0));
            chk("rst_instr", instruction, 32'h0);
            chk("rst_instrPc", instructionPc, 32'h0);
            chk("rst_reqAddr", memReqAddress, RPC);
        end else if (!m_rst) begin
            chk("reqValid", 32'(memReqValid), 32'(m_reqv));
            if (m_reqv) chk("reqAddr", memReqAddress, exp_req);
            chk("instrValid", 32'(instructionValid), 32'(m_iv));
            if (m_cons) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL scoreboard_empty cycle %0d", cyc);
                end else begin
                    logic [31:0] pc;
                    pc = exp_q.pop_front();
                    chk("instrPc", instructionPc, pc);
                    chk("instr", instruction, ~pc);
                    consumed++;
                end
            end
        end
`ifdef FETCH_PERF_COUNTERS_EN
        if (!m_rst || m_rst2) begin
            chk("stallCycles", fetchStallCycles, m_stall);
            chk("flushedWords", fetchFlushedWords, m_flush);
        end
`endif
    end

    // one clock of stimulus plus the reference model update
    task automatic cycle(input bit rst, input bit stall, input bit redir,
                         input logic [31:0] tgt, input bit rdy, input int lat, input bit stale);
        int out;
        bit resp, live_resp, acc;
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 32'd4;
        end
        reset = rst; isStalled = stall; shouldGoToTarget = redir;
        jumpTarget = tgt; memReqReady = rdy;
        out = mem_q.size();
        resp = 1'b0; live_resp = 1'b0;
        memRespValid = 1'b0; memRespData = $urandom;
        if (!rst && out > 0 && mem_q[0].due <= cyc) begin
            resp = 1'b1; memRespValid = 1'b1;
            memRespData = ~mem_q[0].addr;
            live_resp = (mem_q[0].ep == epoch) && !redir;
            void'(mem_q.pop_front());
        end else if (stale && out == 0) begin
            memRespValid = 1'b1;
        end
        m_rst2 = rst && m_rst;
        m_rst  = rst;
        m_reqv = !rst && !redir && out < MO && (live + out) < QD;
        m_iv   = !rst && !redir && live > 0;
        m_cons = m_iv && !stall;
        acc    = m_reqv && rdy;
        @(posedge clk);
        cyc++;
        if (acc) mem_q.push_back('{exp_req, cyc + lat, epoch});
        if (rst) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!redir && !m_reqv && m_stall != 32'hFFFFFFFF) m_stall++;
            if (resp && !live_resp && m_flush != 32'hFFFFFFFF) m_flush++;
        end
        if (rst) begin
            mem_q.delete(); exp_q.delete();
            live = 0; exp_req = RPC; exp_next = RPC; epoch++;
        end else if (redir) begin
            exp_q.delete();
            live = 0; exp_req = tgt; exp_next = tgt; epoch++;
        end else begin
            if (live_resp) live++;
            if (m_cons) live--;
            if (acc) exp_req += 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        bit stale;
        @(negedge clk);
        repeat (3) cycle(1, 0, 0, 0, 1, 0, 0);
        // zero-wait streaming across the 32-bit wrap
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, i == 0);
        // stall long enough to fill the queue, then drain
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        // memory not ready: address must hold
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        // redirect with slow responses still in flight
        cycle(0, 1, 0, 0, 1, 1, 0);
        cycle(0, 1, 0, 0, 1, 3, 0);
        cycle(0, 0, 1, 32'h100, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        // redirect while a zero-wait response is landing
        cycle(0, 0, 1, 32'h200, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        // reset mid-fetch, stale response right after release
        cycle(0, 0, 0, 0, 1, 3, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, i == 0);
        // randomized traffic
        stale = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                cycle(1, 0, 0, 0, 1, 0, 0);
                cycle(1, 0, 0, 0, 1, 0, 0);
                stale = 1'b1;
            end else begin
                tgt = $urandom;
                tgt = tgt & 32'hFFFFFFFC;
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF8;
                cycle(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, tgt,
                      $urandom_range(0, 99) < 70, $urandom_range(0, 3), stale);
                stale = 1'b0;
            end
        end
        vectors++;
        if (consumed < 200) begin
            errors++;
            $display("FAIL progress: consumed %0d words, need at least 200", consumed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage with prefetch queue. Sits directly upstream of the IF/ID barrier and replaces the direct ProgramCounter-to-InstructionMemory path.
- Issues in-order requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned words with their PCs and presents them to decode.
- Obeys the pipeline stall and the branch redirect, which flushes queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..QUEUE_DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- isStalled  input  1  decode not accepting; head entry held.
- shouldGoToTarget  input  1  redirect request, one-cycle pulse.
- jumpTarget  input  32  redirect address; 4-byte aligned.
- memReqValid  output  1  fetch request valid.
- memReqAddress  output  32  fetch address.
- memReqReady  input  1  memory accepts request.
- memRespValid  input  1  instruction word returned, in request order.
- memRespData  input  32  returned instruction word.
- instructionValid  output  1  queue head valid for decode.
- instruction  output  32  queue head instruction.
- instructionPc  output  32  PC of queue head.

Behaviour:
- Reset, sampled on the edge while reset=1:
  - fetchPc=RESET_PC; queue empty; outstanding=0; pending list empty.
  - Consequently memReqValid=0 during reset, instructionValid=0, instruction=0, instructionPc=0, memReqAddress=RESET_PC.
- Reset mid-operation discards everything. A response arriving while the pending list is empty is ignored.
- Request issue:
  - memReqValid=1 iff !reset && !shouldGoToTarget && outstanding<MAX_OUTSTANDING && (queueCount+outstanding)<QUEUE_DEPTH.
  - memReqAddress=fetchPc.
- Handshake:
  - Accept = memReqValid && memReqReady.
  - On accept: fetchPc+=4, with 32-bit wrap (32'hFFFFFFFC -> 0); push {pc, killed=0} into the pending list; outstanding+1.
  - While valid && !ready, the address is held unless a redirect occurs.
- Response:
  - On memRespValid: pop the pending head; outstanding-1.
  - If the head's killed=0 and no redirect this cycle, push {memRespData, pc} into the queue. Otherwise drop the word.
  - An accept and a response in the same cycle leave outstanding unchanged.
- Queue output:
  - First-word fall-through: instructionValid = !empty && !shouldGoToTarget; instruction and instructionPc come from the head. When empty, both outputs are 0.
  - Pop when instructionValid && !isStalled.
  - Push and pop may occur in the same cycle, including when the queue is full.
  - The credit rule guarantees no push to a full queue without a simultaneous pop. An overflow is a design error; the RTL asserts on it in simulation.
- Redirect, on an edge with shouldGoToTarget=1:
  - queue cleared; fetchPc=jumpTarget.
  - Every pending entry marked killed=1; outstanding stays, since those responses must still be drained.
  - No request issued and no pop in that cycle.
  - First request to jumpTarget: the next cycle, if credits allow.
- Redirect has priority over stall. Reset has priority over redirect.
- Latency:
  - Zero-wait memory (ready=1, response the cycle after accept): first request in cycle 0 after reset; instructionValid=1 in cycle 2; one instruction per cycle thereafter.
  - Redirect penalty is 2 cycles to the first valid instruction at the target.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, adds outputs:
  - fetchStallCycles (32): increments each cycle memReqValid=0 && !reset && !shouldGoToTarget.
  - fetchFlushedWords (32): increments per dropped response.
  - Both clear on reset and saturate at 32'hFFFFFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, ready=1, 1-cycle response, words = PC value, isStalled=0 -> instructionPc sequence 0,4,8,12 on consecutive cycles starting cycle 2; memReqValid never drops.
- isStalled=1 for 6 cycles with QUEUE_DEPTH=4 -> queue fills with 4 entries and memReqValid=0 once count+outstanding=4; head stays PC 0x10 throughout; release -> 0x10,0x14,0x18,0x1C with no gaps or duplicates.
- Redirect to 0x100 with 2 requests outstanding, responses arriving 1 and 3 cycles later -> both words dropped; first instructionValid carries instructionPc=0x100; fetchFlushedWords=2 when the macro is enabled.
- memReqReady=0 for 5 cycles at PC 0x40 -> memReqAddress held at 0x40 and no pending push; after ready rises, exactly one request for 0x40.
- Redirect pulse in the same cycle a response arrives with isStalled=0 -> response dropped; instructionValid=0 that cycle; no pop.
- RESET_PC=32'hFFFFFFF8, reset held mid-fetch then released -> fetch order 0xFFFFFFF8,0xFFFFFFFC,0x0; late pre-reset response ignored.
